// File: rtl/data_io_cfg_ctrl.sv
// Configuration controller for data_io_block: assembles CW-bit words into a shadow frame, checks it, commits it atomically to c.
// Latency: new c visible 3 cycles after the cycle in which the last word is accepted (LOAD -> CHECK -> COMMIT -> IDLE).
// Backpressure: cfg_ready is low in CHECK and COMMIT, and in IDLE while cfg_clear is high; LOAD accepts gaps indefinitely.
// Optional feature macro: DATA_IO_CFG_CONFLICT_CHECK_EN (drive-conflict rejection of frames; default build never rejects).
module data_io_cfg_ctrl #(
  parameter int W          = 6,
  parameter int WW         = 3,
  parameter int EXTDATAIN  = 2,
  parameter int EXTDATAOUT = 3,
  parameter int CW         = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  input  logic [CW-1:0]                       cfg_data,
  input  logic                                cfg_clear,
  output logic [W*(EXTDATAIN+EXTDATAOUT)-1:0] c,
  output logic                                cfg_busy,
  output logic                                cfg_done,
  output logic                                cfg_err
);

  localparam int NC     = W * (EXTDATAIN + EXTDATAOUT);
  localparam int NWORDS = (NC + CW - 1) / CW;
  localparam int CNTW   = $clog2(NWORDS + 1);
  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NWORDS - 1);

  // The output-port lane rule assumes each port's data slice maps evenly onto WW lanes.
  if ((W % WW) != 0) begin : g_bad_width
    $error("data_io_cfg_ctrl: W must be a multiple of WW");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q;
  logic [NC-1:0]   shadow_q, shadow_nxt;
  logic            accept;
  logic            conflict_d, conflict_q;
  int              slot;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode and handshake; clear wins over valid in IDLE.
  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = !cfg_clear;
        if (cfg_valid && !cfg_clear) state_d = (NWORDS == 1) ? CHECK : LOAD;
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid && (cnt_q == LAST_IDX)) state_d = CHECK;
      end
      CHECK:   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    accept = cfg_valid && cfg_ready;
  end

  assign cfg_busy = (state_q != IDLE);

  // Place the incoming word into its slot; bits past NC simply have no home.
  always_comb begin
    shadow_nxt = shadow_q;
    slot       = (state_q == IDLE) ? 0 : int'(cnt_q);
    for (int b = 0; b < NC; b++) begin
      if ((b / CW) == slot) shadow_nxt[b] = cfg_data[b % CW];
    end
  end

`ifdef DATA_IO_CFG_CONFLICT_CHECK_EN
  int drv;

  // Flag multiple drivers on any data bit or any external output lane.
  always_comb begin
    conflict_d = 1'b0;
    drv        = 0;
    for (int j = 0; j < W; j++) begin
      drv = 0;
      for (int i = 0; i < EXTDATAIN; i++) drv = drv + int'(shadow_q[j + i*W]);
      if (drv > 1) conflict_d = 1'b1;
    end
    for (int i = 0; i < EXTDATAOUT; i++) begin
      for (int k = 0; k < WW; k++) begin
        drv = 0;
        for (int j = 0; j < W; j++) begin
          if ((j % WW) == k) drv = drv + int'(shadow_q[j + i*W + EXTDATAIN*W]);
        end
        if (drv > 1) conflict_d = 1'b1;
      end
    end
  end
`else
  // Without the checker every frame is accepted; CHECK still costs one cycle.
  assign conflict_d = 1'b0;
`endif

  // Datapath: shadow fill, word count, conflict latch, atomic commit, clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q   <= '0;
      cnt_q      <= '0;
      conflict_q <= 1'b0;
      c          <= '0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (accept) begin
        shadow_q <= shadow_nxt;
        if (state_q == IDLE) begin
          cnt_q   <= CNTW'(1);
          cfg_err <= 1'b0;
        end else begin
          cnt_q <= cnt_q + CNTW'(1);
        end
      end
      if ((state_q == IDLE) && cfg_clear) c <= '0;
      if (state_q == CHECK) conflict_q <= conflict_d;
      if (state_q == COMMIT) begin
        cfg_done <= 1'b1;
        if (conflict_q) cfg_err <= 1'b1;
        else            c       <= shadow_q;
      end
    end
  end

endmodule

// File: tb/tb_data_io_cfg_ctrl.sv
module tb_data_io_cfg_ctrl;

`ifdef DATA_IO_CFG_CONFLICT_CHECK_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_data;
  logic        cfg_clear;
  logic [29:0] c;
  logic        cfg_busy;
  logic        cfg_done;
  logic        cfg_err;

  int          total = 0;
  int          bad   = 0;
  logic [29:0] exp_c;

  data_io_cfg_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_clear (cfg_clear),
    .c         (c),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one word and hold it until accepted (bounded wait).
  task automatic send_word(input logic [7:0] d);
    int n;
    n = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    #1;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $error("FAIL ready_timeout observed=0 expected=1");
    end
    tick();
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3, input bit gap);
    logic [7:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int k = 0; k < 4; k++) begin
      send_word(w[k]);
      if (k == 0) begin
        chk("err_cleared_first_word", {31'd0, cfg_err}, 32'd0);
        chk("busy_after_first_word", {31'd0, cfg_busy}, 32'd1);
      end
      if (k < 3) begin
        chk("load_no_done", {31'd0, cfg_done}, 32'd0);
        chk("load_c_held", {2'b00, c}, {2'b00, exp_c});
        if (gap) begin
          chk("gap_ready", {31'd0, cfg_ready}, 32'd1);
          tick();
          chk("gap_ready_2", {31'd0, cfg_ready}, 32'd1);
          chk("gap_busy", {31'd0, cfg_busy}, 32'd1);
        end
      end
    end
  endtask

  // Called at T+1 (right after the last word's edge).
  task automatic finish_frame(input logic [29:0] new_c, input bit rej);
    chk("check_ready_low", {31'd0, cfg_ready}, 32'd0);
    chk("check_busy", {31'd0, cfg_busy}, 32'd1);
    chk("check_no_done", {31'd0, cfg_done}, 32'd0);
    tick();
    chk("commit_ready_low", {31'd0, cfg_ready}, 32'd0);
    chk("commit_busy", {31'd0, cfg_busy}, 32'd1);
    chk("commit_c_old", {2'b00, c}, {2'b00, exp_c});
    chk("commit_err_low", {31'd0, cfg_err}, 32'd0);
    tick();
    if (!rej) exp_c = new_c;
    chk("done_pulse", {31'd0, cfg_done}, 32'd1);
    chk("done_ready", {31'd0, cfg_ready}, 32'd1);
    chk("done_idle", {31'd0, cfg_busy}, 32'd0);
    chk("done_err", {31'd0, cfg_err}, {31'd0, rej});
    chk("done_c", {2'b00, c}, {2'b00, exp_c});
    tick();
    chk("done_one_cycle", {31'd0, cfg_done}, 32'd0);
    chk("c_stable", {2'b00, c}, {2'b00, exp_c});
    chk("err_sticky", {31'd0, cfg_err}, {31'd0, rej});
  endtask

  initial begin
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_data  = 8'h00;
    cfg_clear = 1'b0;
    exp_c     = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_c", {2'b00, c}, 32'd0);
    chk("rst_done", {31'd0, cfg_done}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_busy", {31'd0, cfg_busy}, 32'd0);
    chk("rst_ready", {31'd0, cfg_ready}, 32'd1);

    // Single low bit.
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
    finish_frame(30'h0000_0001, 1'b0);

    // All ones: top two bits of word 3 dropped; many drive conflicts.
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    finish_frame(30'h3FFF_FFFF, CC);

    // c[0] and c[6] both drive data[0].
    send_frame(8'h41, 8'h00, 8'h00, 8'h00, 1'b0);
    finish_frame(30'h0000_0041, CC);

    // c[12] and c[15] both drive lane 0 of output port 0.
    send_frame(8'h00, 8'h90, 8'h00, 8'h00, 1'b0);
    finish_frame(30'h0000_9000, CC);

    // c[12] and c[13] are distinct lanes: always legal.
    send_frame(8'h00, 8'h30, 8'h00, 8'h00, 1'b0);
    finish_frame(30'h0000_3000, 1'b0);

    // Reset after two words: partial frame lost, c cleared.
    send_word(8'hAA);
    send_word(8'hBB);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    exp_c = '0;
    chk("midrst_c", {2'b00, c}, 32'd0);
    chk("midrst_busy", {31'd0, cfg_busy}, 32'd0);
    chk("midrst_ready", {31'd0, cfg_ready}, 32'd1);
    send_frame(8'h07, 8'h20, 8'h04, 8'h01, 1'b0);
    finish_frame(30'h0104_2007, 1'b0);

    // Clear and valid together in IDLE: clear wins.
    cfg_clear = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    #1;
    chk("clear_ready_low", {31'd0, cfg_ready}, 32'd0);
    tick();
    exp_c = '0;
    chk("clear_c", {2'b00, c}, 32'd0);
    chk("clear_no_busy", {31'd0, cfg_busy}, 32'd0);
    chk("clear_no_done", {31'd0, cfg_done}, 32'd0);
    cfg_clear = 1'b0;
    cfg_valid = 1'b0;
    tick();
    chk("clear_after_no_done", {31'd0, cfg_done}, 32'd0);
    chk("clear_after_idle", {31'd0, cfg_busy}, 32'd0);

    // Clear during LOAD is ignored.
    send_word(8'h01);
    cfg_clear = 1'b1;
    #1;
    chk("load_clear_ready", {31'd0, cfg_ready}, 32'd1);
    send_word(8'h00);
    send_word(8'h00);
    send_word(8'h01);
    cfg_clear = 1'b0;
    finish_frame(30'h0100_0001, 1'b0);

    // One-cycle gaps between words.
    send_frame(8'h12, 8'h30, 8'h00, 8'h08, 1'b1);
    finish_frame(30'h0800_3012, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_io_cfg_ctrl.md
# data_io_cfg_ctrl

Configuration controller for the `data_io_block` gate array. It accepts a configuration frame as a stream of fixed-width words over a valid/ready handshake and assembles the words in a shadow register. It then optionally checks the frame for electrical drive conflicts and commits it atomically to the `c` control vector that drives the transmission gates. It sits between the chip-level configuration bus and each `data_io_block` instance.

## Interface
- `W`, 6, data bus width; must be a multiple of `WW`.
- `WW`, 3, external port width.
- `EXTDATAIN`, 2, number of external input ports.
- `EXTDATAOUT`, 3, number of external output ports.
- `CW`, 8, configuration word width.
- Derived: `NC = W*(EXTDATAIN+EXTDATAOUT)` (30 by default) and `NWORDS = ceil(NC/CW)` (4 by default).
- `clk`  in  1  clock; the block has one clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cfg_valid`  in  1  a configuration word is offered.
- `cfg_ready`  out  1  the block can accept a word.
- `cfg_data`  in  CW  configuration word.
- `cfg_clear`  in  1  request to disconnect all gates.
- `c`  out  NC  active gate controls, connects to `data_io_block.c`.
- `cfg_busy`  out  1  a frame is in progress (state is not IDLE).
- `cfg_done`  out  1  one-cycle pulse at the end of a frame.
- `cfg_err`  out  1  the last frame was rejected.

## Operation
- States: IDLE, LOAD, CHECK, COMMIT.
- Word acceptance: a word is accepted on a rising edge where `cfg_valid && cfg_ready`.
- Word placement: word k (0-based) is written to shadow bits `[k*CW +: CW]`. Bits at index NC and above are discarded; by default the top 2 bits of word 3 are dropped.
- IDLE:
  - `cfg_ready = !cfg_clear`.
  - An accepted word goes to slot 0, the word count becomes 1, and `cfg_err` is cleared.
  - The next state is LOAD, or CHECK if `NWORDS == 1`.
  - `cfg_clear` high: `c` becomes 0 on the next edge, no word is accepted, and there is no `cfg_done` pulse. Clear has priority over a simultaneous `cfg_valid`.
- LOAD:
  - `cfg_ready = 1`.
  - Each accepted word goes to the slot given by the word count, and the count increments.
  - On acceptance of word `NWORDS-1` the state moves to CHECK.
  - `cfg_clear` is ignored.
  - Gaps in `cfg_valid` are allowed indefinitely.
- CHECK (1 cycle): `cfg_ready = 0`. The conflict flag is evaluated and registered (see Configuration).
- COMMIT (1 cycle): `cfg_ready = 0`.
  - No conflict: `c <= shadow`.
  - Conflict: `c` is unchanged and `cfg_err <= 1`.
  - In both cases `cfg_done <= 1` and the state returns to IDLE.
- `cfg_err` is sticky until the next frame's first word is accepted, or until `rst`.
- The shadow register is not cleared between frames. Every frame overwrites all slots, so stale data never reaches `c`.
- Reset, including mid-frame:
  - `c = 0`, shadow = 0, count = 0, state = IDLE.
  - `cfg_done = 0`, `cfg_err = 0`, `cfg_busy = 0`.
  - `cfg_ready = 1` in the first cycle after reset deassertion (with `cfg_clear` low).
  - A partial frame is lost and `c` is never partially updated.

## Timing
- Let T be the cycle in which the last word is accepted:
  - T+1: CHECK.
  - T+2: COMMIT.
  - T+3: new `c` is visible, `cfg_done = 1`, `cfg_ready = 1`.
- Minimum frame period is NWORDS+2 cycles, i.e. 6 by default.
- `c` changes only at the COMMIT edge, the `cfg_clear` edge, or reset. It is glitch-free at register granularity.
- `cfg_busy` is high from the cycle after the first word is accepted through COMMIT.
- All outputs are registered except `cfg_ready` and `cfg_busy`, which are decoded from the state register (and `cfg_clear` in IDLE).

## Configuration
- Macro: `DATA_IO_CFG_CONFLICT_CHECK_EN`.
- Defined: CHECK flags a conflict when either rule is violated:
  - Input rule: for any data bit j, more than one of `c[j+i*W]`, i in [0, EXTDATAIN), is set (multiple drivers on `data[j]`).
  - Output rule: for any output port i and lane k, more than one `c[j+i*W+EXTDATAIN*W]` with `j%WW==k` is set (multiple drivers on `external_output[k+i*WW]`).
- Not defined:
  - The conflict flag is tied to 0 and `cfg_err` is constant 0.
  - CHECK still occupies one cycle, so latency is identical in both builds.

## Test plan
- Reset, then send words 0x01, 0x00, 0x00, 0x00 -> `cfg_done` at T+3 and `c = 30'h1`. Before that, `c = 0` throughout.
- Send frame 0xFF, 0xFF, 0xFF, 0xFF (0xFF in every word) -> `c = 30'h3FFF_FFFF` (top bits of word 3 discarded) when the macro is undefined. When the macro is defined the frame is rejected: `cfg_err = 1` and `c` is unchanged.
- Macro defined, frame setting `c[0]` and `c[6]` -> `cfg_err = 1` and `c` keeps its prior value. A frame setting `c[12]` and `c[15]` -> `cfg_err = 1`. A frame setting `c[12]` and `c[13]` -> `cfg_err = 0` and the frame is committed.
- Assert `rst` after 2 of 4 words, then send a full 4-word frame -> only the new frame is committed, with `cfg_done` after exactly 4 accepted words.
- In IDLE with `c != 0`, assert `cfg_clear` and `cfg_valid` together -> `cfg_ready = 0`, `c = 0` next cycle, no word accepted, and no `cfg_done`. Asserting `cfg_clear` during LOAD has no effect.
- Drive `cfg_valid` with 1-cycle gaps -> the frame assembles correctly, and `cfg_ready` drops only in CHECK and COMMIT.
